sdpram_fifo: RTL and testbench



---
 rtl/sdpram_pkg.sv | 18 +
 rtl/sdpram_if.sv | 32 +++
 rtl/sdpram_fifo_obuf.sv | 49 ++++
 rtl/sdpram_fifo.sv | 82 ++++++++
 tb/tb_sdpram_fifo.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdpram_pkg.sv
// Shared sizing helpers for the SDP RAM interface and FIFO controller.
// addr_width/strb_width size the RAM port; cnt_width sizes FIFO count.
package sdpram_pkg;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int strb_width(input int dw, input int bw);
    return (bw != 0) ? (dw + 7) / 8 : 1;
  endfunction

  // RAM words plus up to two in flight/buffered entries.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/sdpram_if.sv
// Simple dual-port RAM port bundle: write port A, read port B.
// sdp_m drives wena/addra/dina/renb/addrb; sdp_s returns doutb/dvalb.
interface sdpram_if
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int BYTE_WRITE = 0
);
  localparam int AW = addr_width(MEM_DEPTH);
  localparam int SW = strb_width(DATA_WIDTH, BYTE_WRITE);

  logic [SW-1:0]         wena;
  logic [AW-1:0]         addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  renb;
  logic [AW-1:0]         addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  dvalb;

  modport sdp_m (
    output wena, addra, dina,
    output renb, addrb,
    input  doutb, dvalb
  );

  modport sdp_s (
    input  wena, addra, dina,
    input  renb, addrb,
    output doutb, dvalb
  );
endinterface

// File: rtl/sdpram_fifo_obuf.sv
// Two-entry in-order output buffer: cap/din in, pop out, cnt occupancy.
// data is the oldest entry; valid = cnt != 0.
module sdpram_fifo_obuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [1:0]            cnt
);
  logic [DATA_WIDTH-1:0] e0;
  logic [DATA_WIDTH-1:0] e1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({pop, cap})
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        2'b10: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign data  = e0;
  assign valid = (cnt != 2'd0);
endmodule

// File: rtl/sdpram_fifo.sv
// FWFT FIFO controller over an external SDP RAM (master side).
// Push s_*, pop m_*, count = ram+inflight+buffered, sticky err_unexp.
module sdpram_fifo
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int BYTE_WRITE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [cnt_width(MEM_DEPTH)-1:0] count,
  output logic                  err_unexp,
  sdpram_if.sdp_m               mem
);
  localparam int AW  = addr_width(MEM_DEPTH);
  localparam int SW  = strb_width(DATA_WIDTH, BYTE_WRITE);
  localparam int RCW = $clog2(MEM_DEPTH + 1);
  localparam int CW  = cnt_width(MEM_DEPTH);
  localparam logic [RCW-1:0] FULL = RCW'(MEM_DEPTH);

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [RCW-1:0] ram_cnt;
  logic [1:0]     inflight;
  logic [1:0]     ob_cnt;
  logic [2:0]     occ;
  logic push, pop, issue, cap;

  assign s_ready = (ram_cnt < FULL);
  // Strobes are held low while rst is asserted.
  assign push  = s_valid && s_ready && !rst;
  assign pop   = m_valid && m_ready;
  // A slot freed by this cycle's pop can be refilled now.
  assign occ   = 3'(inflight) + 3'(ob_cnt) - 3'(pop);
  assign issue = (ram_cnt != '0) && (occ < 3'd2) && !rst;
  assign cap   = mem.dvalb && (inflight != 2'd0);

  assign mem.wena  = push ? {SW{1'b1}} : '0;
  assign mem.addra = wr_ptr;
  assign mem.dina  = push ? s_data : '0;
  assign mem.renb  = issue;
  assign mem.addrb = rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      inflight  <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      ram_cnt  <= ram_cnt + RCW'(push) - RCW'(issue);
      inflight <= inflight + 2'(issue) - 2'(cap);
      if (mem.dvalb && inflight == 2'd0)
        err_unexp <= 1'b1;
    end
  end

  sdpram_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .cap   (cap),
    .din   (mem.doutb),
    .pop   (pop),
    .data  (m_data),
    .valid (m_valid),
    .cnt   (ob_cnt)
  );

  assign count = CW'(ram_cnt) + CW'(inflight) + CW'(ob_cnt);
endmodule

// File: tb/tb_sdpram_fifo.sv
// Scoreboard bench for sdpram_fifo with a behavioral 8-word SDP RAM.
// Directed scenarios: reset, latency, fill, stream, stray dvalb, reset.
module tb_sdpram_fifo;
  logic        clk;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  count;
  logic        err_unexp;

  int checks = 0;
  int errors = 0;
  int npop   = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  exp_wa;
  logic [2:0]  exp_ra;

  sdpram_if #(
    .DATA_WIDTH (32),
    .MEM_DEPTH  (8),
    .BYTE_WRITE (0)
  ) mem_if ();

  sdpram_fifo #(
    .DATA_WIDTH (32),
    .MEM_DEPTH  (8),
    .BYTE_WRITE (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .count     (count),
    .err_unexp (err_unexp),
    .mem       (mem_if)
  );

  logic [31:0] ram [8];
  logic [31:0] dout_q;
  logic        dv_q;
  logic        force_dv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      dv_q <= mem_if.renb;
      if (mem_if.renb) dout_q <= ram[mem_if.addrb];
    end
  end

  always @(posedge clk) begin
    if (mem_if.wena[0]) ram[mem_if.addra] <= mem_if.dina;
  end

  assign mem_if.doutb = dout_q;
  assign mem_if.dvalb = dv_q | force_dv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("push_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_count0(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (count != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(count), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(m_valid), 1);
  endtask

  // Monitor: address model for RAM strobes, scoreboard for pops.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_wa = '0;
        exp_ra = '0;
      end else begin
        if (mem_if.renb) begin
          chk("addrb", 32'(mem_if.addrb), 32'(exp_ra));
          exp_ra = exp_ra + 3'd1;
        end
        if (mem_if.wena[0]) begin
          chk("addra", 32'(mem_if.addra), 32'(exp_wa));
          exp_wa = exp_wa + 3'd1;
        end
        if (m_valid && m_ready) begin
          npop++;
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", m_data, 32'hdead);
          end else begin
            e = exp_q.pop_front();
            chk("pop_data", m_data, e);
          end
        end
        if (s_valid && s_ready) exp_q.push_back(s_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst      = 1'b1;
    s_valid  = 1'b1;
    s_data   = 32'hffff_ffff;
    m_ready  = 1'b0;
    force_dv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err_unexp), 0);
    chk("rst_wena", 32'(mem_if.wena), 0);
    chk("rst_renb", 32'(mem_if.renb), 0);
    chk("rst_addra", 32'(mem_if.addra), 0);
    chk("rst_addrb", 32'(mem_if.addrb), 0);
    chk("rst_dina", mem_if.dina, 0);
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // single push latency
    s_data  = 32'ha5a5_0001;
    s_valid = 1'b1;
    @(negedge clk);
    chk("t0_wena", 32'(mem_if.wena), 1);
    chk("t0_addra", 32'(mem_if.addra), 0);
    chk("t0_dina", mem_if.dina, 32'ha5a5_0001);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("t1_renb", 32'(mem_if.renb), 1);
    chk("t1_addrb", 32'(mem_if.addrb), 0);
    chk("t1_m_valid", 32'(m_valid), 0);
    tick();
    @(negedge clk);
    chk("t2_m_valid", 32'(m_valid), 0);
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_m_valid", 32'(m_valid), 1);
    chk("t3_m_data", m_data, 32'ha5a5_0001);
    chk("t3_count", 32'(count), 1);
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    chk("t4_count", 32'(count), 0);
    tick();

    // fill to capacity
    for (int i = 0; i < 10; i++) push(32'(i));
    repeat (3) tick();
    @(negedge clk);
    chk("full_count", 32'(count), 10);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_head", m_data, 0);
    s_data  = 32'h99;
    s_valid = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("full_hold", 32'(count), 10);
    tick();
    p0 = npop;
    m_ready = 1'b1;
    wait_count0("fill_drain");
    tick();
    m_ready = 1'b0;
    chk("fill_pops", 32'(npop - p0), 10);

    // streaming push/pop
    p0 = npop;
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data  = 32'h1000 + 32'(i);
      s_valid = 1'b1;
      @(negedge clk);
      chk("stream_s_ready", 32'(s_ready), 1);
      if (i >= 3) chk("stream_bubble", 32'(m_valid), 1);
      tick();
    end
    s_valid = 1'b0;
    wait_count0("stream_drain");
    tick();
    m_ready = 1'b0;
    chk("stream_pops", 32'(npop - p0), 100);

    // stray dvalb with nothing outstanding
    push(32'h1234);
    wait_valid("stray_fill");
    chk("stray_err_pre", 32'(err_unexp), 0);
    tick();
    force_dv = 1'b1;
    tick();
    force_dv = 1'b0;
    @(negedge clk);
    chk("stray_err", 32'(err_unexp), 1);
    chk("stray_count", 32'(count), 1);
    chk("stray_data", m_data, 32'h1234);
    repeat (4) tick();
    @(negedge clk);
    chk("stray_sticky", 32'(err_unexp), 1);
    tick();
    m_ready = 1'b1;
    wait_count0("stray_drain");
    tick();
    m_ready = 1'b0;

    // reset with 5 stored entries
    for (int i = 0; i < 5; i++) push(32'h50 + 32'(i));
    repeat (3) tick();
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 5);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 1);
    chk("mid_rst_err", 32'(err_unexp), 0);
    tick();
    rst = 1'b0;
    tick();
    push(32'hbeef);
    wait_valid("post_rst_valid");
    chk("post_rst_data", m_data, 32'hbeef);
    chk("post_rst_count", 32'(count), 1);
    tick();
    m_ready = 1'b1;
    wait_count0("post_rst_drain");
    tick();
    m_ready = 1'b0;
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
